// File: rtl/unpack_pkt_arbiter.sv
// unpack_pkt_arbiter: packet-level round-robin arbiter in front of a shared
// data_unpack. The grant is locked from the sop beat to the eop beat, so
// packets never interleave at the unpacker input. Beats pass straight through.
// Optional feature macro: UNPACK_ARB_TIMEOUT_EN adds a stall watchdog. If the
// owner stops presenting beats for TIMEOUT cycles, the watchdog closes its
// packet with a zero-data eop beat and adds the `timeout` output port.
module unpack_pkt_arbiter #(
   parameter int N_REQ   = 4,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   input  logic [N_REQ-1:0]          req_sop,
   input  logic [N_REQ-1:0]          req_eop,
   output logic [N_REQ-1:0]          req_ready,
   output logic                      um_valid,
   output logic [DATA_W-1:0]         um_data,
   output logic                      um_sop,
   output logic                      um_eop,
   input  logic                      um_ready,
   output logic [N_REQ-1:0]          grant,
   output logic                      busy
`ifdef UNPACK_ARB_TIMEOUT_EN
   ,
   output logic                      timeout
`endif
);

   localparam int                PTR_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [PTR_W:0]    N_EXT    = (PTR_W+1)'(N_REQ);
   localparam logic [PTR_W-1:0]  LAST_IDX = PTR_W'(N_REQ-1);
   localparam logic [N_REQ-1:0]  ONE_HOT0 = N_REQ'(1);

   if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_bad_param
      $error("unpack_pkt_arbiter: N_REQ must be 2..8 and TIMEOUT at least 1");
   end

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      LOCK = 1'b1
   } state_t;

   state_t              state;
   state_t              state_next;

   logic [PTR_W-1:0]    rr_ptr;
   logic [PTR_W-1:0]    rr_next;
   logic [PTR_W-1:0]    gidx;
   logic [N_REQ-1:0]    grant_q;
   logic                busy_q;

   logic [N_REQ-1:0]    eligible;
   logic [N_REQ-1:0]    rot;
   logic                win_found;
   logic [PTR_W:0]      win_sum;
   logic [PTR_W:0]      win_wrap;
   logic [PTR_W-1:0]    win_idx;

   logic                sel_valid;
   logic                sel_sop;
   logic                sel_eop;
   logic [DATA_W-1:0]   sel_data;

   logic                inject;
   logic                beat_valid;
   logic                beat_eop;
   logic                pkt_done;

   // A source may only win arbitration with the first beat of a packet
   assign eligible = req_valid & req_sop;

   // Rotate eligibility so bit 0 is the rr pointer, then take the lowest set bit
   always_comb begin
      rot       = N_REQ'({eligible, eligible} >> rr_ptr);
      win_found = 1'b0;
      win_sum   = '0;
      for (int j = N_REQ-1; j >= 0; j--) begin
         if (rot[j]) begin
            win_found = 1'b1;
            win_sum   = {1'b0, rr_ptr} + (PTR_W+1)'(j);
         end
      end
      win_wrap = (win_sum >= N_EXT) ? (win_sum - N_EXT) : win_sum;
      win_idx  = win_wrap[PTR_W-1:0];
   end

   // Pick out the fields of the current owner
   always_comb begin
      sel_valid = 1'b0;
      sel_sop   = 1'b0;
      sel_eop   = 1'b0;
      sel_data  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gidx == PTR_W'(i)) begin
            sel_valid = req_valid[i];
            sel_sop   = req_sop[i];
            sel_eop   = req_eop[i];
            sel_data  = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign rr_next    = (gidx == LAST_IDX) ? '0 : gidx + 1'b1;
   assign beat_valid = inject | sel_valid;
   assign beat_eop   = inject | sel_eop;
   assign pkt_done   = (state == LOCK) && beat_valid && um_ready && beat_eop;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   // Next state and the unpacker-side pass-through; everything is zero while idle
   always_comb begin
      state_next = state;
      req_ready  = '0;
      um_valid   = 1'b0;
      um_data    = '0;
      um_sop     = 1'b0;
      um_eop     = 1'b0;
      case (state)
         IDLE: begin
            if (win_found) state_next = LOCK;
         end
         LOCK: begin
            if (inject) begin
               um_valid = 1'b1;
               um_eop   = 1'b1;
            end else begin
               um_valid  = sel_valid;
               um_data   = sel_data;
               um_sop    = sel_sop;
               um_eop    = sel_eop;
               req_ready = grant_q & {N_REQ{um_ready}};
            end
            if (pkt_done) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Owner, grant vector and rr pointer: latched on a win, released after the eop beat
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr  <= '0;
         gidx    <= '0;
         grant_q <= '0;
         busy_q  <= 1'b0;
      end else if (state == IDLE) begin
         if (win_found) begin
            gidx    <= win_idx;
            grant_q <= ONE_HOT0 << win_idx;
            busy_q  <= 1'b1;
         end
      end else if (pkt_done) begin
         rr_ptr  <= rr_next;
         grant_q <= '0;
         busy_q  <= 1'b0;
      end
   end

   assign grant = grant_q;
   assign busy  = busy_q;

`ifdef UNPACK_ARB_TIMEOUT_EN
   localparam int               CNT_W   = $clog2(TIMEOUT+1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(TIMEOUT-1);

   logic [CNT_W-1:0] stall_cnt;
   logic             inject_q;
   logic             timeout_q;

   // Stall watchdog: count owner-idle LOCK cycles; at the limit, inject an eop beat
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
         inject_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         if (state == IDLE) begin
            stall_cnt <= '0;
            inject_q  <= 1'b0;
         end else if (inject_q) begin
            if (um_ready) inject_q <= 1'b0;
         end else if (sel_valid) begin
            stall_cnt <= '0;
         end else if (stall_cnt == CNT_PRE) begin
            stall_cnt <= CNT_MAX;
            inject_q  <= 1'b1;
            timeout_q <= 1'b1;
         end else begin
            stall_cnt <= stall_cnt + 1'b1;
         end
      end
   end

   assign inject  = inject_q;
   assign timeout = timeout_q;
`else
   assign inject = 1'b0;
`endif

endmodule

// File: tb/tb_unpack_pkt_arbiter.sv
// Directed bench for unpack_pkt_arbiter (N_REQ=4, DATA_W=32, TIMEOUT=8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_unpack_pkt_arbiter;

   localparam int N_REQ   = 4;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 8;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ-1:0]        req_sop;
   logic [N_REQ-1:0]        req_eop;
   logic [N_REQ-1:0]        req_ready;
   logic                    um_valid;
   logic [DATA_W-1:0]       um_data;
   logic                    um_sop;
   logic                    um_eop;
   logic                    um_ready;
   logic [N_REQ-1:0]        grant;
   logic                    busy;
`ifdef UNPACK_ARB_TIMEOUT_EN
   logic                    timeout;
`endif

   int chk_cnt  = 0;
   int pass_cnt = 0;
   int acc_cnt  = 0;

   unpack_pkt_arbiter #(
      .N_REQ   (N_REQ),
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_sop   (req_sop),
      .req_eop   (req_eop),
      .req_ready (req_ready),
      .um_valid  (um_valid),
      .um_data   (um_data),
      .um_sop    (um_sop),
      .um_eop    (um_eop),
      .um_ready  (um_ready),
      .grant     (grant),
      .busy      (busy)
`ifdef UNPACK_ARB_TIMEOUT_EN
      ,
      .timeout   (timeout)
`endif
   );

   always #5 clk = ~clk;

   // Count beats the unpacker actually takes
   always @(posedge clk) begin
      if (rst && um_valid && um_ready) acc_cnt <= acc_cnt + 1;
   end

   task automatic drive(input int i, input logic v, input logic s, input logic e,
                        input logic [DATA_W-1:0] d);
      req_valid[i]                 = v;
      req_sop[i]                   = s;
      req_eop[i]                   = e;
      req_data[i*DATA_W +: DATA_W] = d;
   endtask

   task automatic clear_all();
      req_valid = '0;
      req_sop   = '0;
      req_eop   = '0;
      req_data  = '0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #1;
      chk_cnt++; if (grant !== 4'b0000) $display("FAIL rst_grant: got %b want 0000", grant); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
      chk_cnt++; if (req_ready !== 4'b0000) $display("FAIL rst_ready: got %b want 0000", req_ready); else pass_cnt++;
      chk_cnt++; if ({um_valid, um_sop, um_eop} !== 3'b000) $display("FAIL rst_um_ctl: got %b want 000", {um_valid, um_sop, um_eop}); else pass_cnt++;
      chk_cnt++; if (um_data !== 32'h0) $display("FAIL rst_um_data: got %h want 0", um_data); else pass_cnt++;
`ifdef UNPACK_ARB_TIMEOUT_EN
      chk_cnt++; if (timeout !== 1'b0) $display("FAIL rst_timeout: got %b want 0", timeout); else pass_cnt++;
`endif
      @(negedge clk);
      rst      = 1'b1;
      um_ready = 1'b1;
   endtask

   task automatic test_single_source();
      int a0;
      a0 = acc_cnt;
      @(negedge clk);
      drive(1, 1'b1, 1'b1, 1'b0, 32'h12345678);
      #1;
      chk_cnt++; if (grant !== 4'b0000) $display("FAIL single_pre_grant: got %b want 0000", grant); else pass_cnt++;
      chk_cnt++; if (req_ready !== 4'b0000) $display("FAIL single_pre_ready: got %b want 0000", req_ready); else pass_cnt++;
      @(negedge clk); #1;
      chk_cnt++; if (grant !== 4'b0010) $display("FAIL single_grant: got %b want 0010", grant); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else pass_cnt++;
      chk_cnt++; if (um_data !== 32'h12345678) $display("FAIL single_beat0: got %h want 12345678", um_data); else pass_cnt++;
      chk_cnt++; if ({um_valid, um_sop, um_eop} !== 3'b110) $display("FAIL single_beat0_ctl: got %b want 110", {um_valid, um_sop, um_eop}); else pass_cnt++;
      chk_cnt++; if (req_ready !== 4'b0010) $display("FAIL single_ready: got %b want 0010", req_ready); else pass_cnt++;
      @(negedge clk);
      drive(1, 1'b1, 1'b0, 1'b1, 32'h9abcdef0);
      #1;
      chk_cnt++; if (um_data !== 32'h9abcdef0) $display("FAIL single_beat1: got %h want 9abcdef0", um_data); else pass_cnt++;
      chk_cnt++; if ({um_valid, um_sop, um_eop} !== 3'b101) $display("FAIL single_beat1_ctl: got %b want 101", {um_valid, um_sop, um_eop}); else pass_cnt++;
      @(negedge clk);
      drive(1, 1'b0, 1'b0, 1'b0, 32'h0);
      #1;
      chk_cnt++; if (grant !== 4'b0000) $display("FAIL single_release: got %b want 0000", grant); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b0) $display("FAIL single_busy_clr: got %b want 0", busy); else pass_cnt++;
      chk_cnt++; if (um_valid !== 1'b0) $display("FAIL single_idle_valid: got %b want 0", um_valid); else pass_cnt++;
      chk_cnt++; if (acc_cnt - a0 !== 2) $display("FAIL single_beats: got %0d want 2", acc_cnt - a0); else pass_cnt++;
   endtask

   task automatic test_contention();
      @(negedge clk);
      rst = 1'b0;
      clear_all();
      @(negedge clk);
      drive(0, 1'b1, 1'b1, 1'b1, 32'hA0000000);
      drive(2, 1'b1, 1'b1, 1'b0, 32'hC0000001);
      rst = 1'b1;
      #1;
      chk_cnt++; if (grant !== 4'b0000) $display("FAIL cont_pre: got %b want 0000", grant); else pass_cnt++;
      @(negedge clk); #1;
      chk_cnt++; if (grant !== 4'b0001) $display("FAIL cont_first: got %b want 0001", grant); else pass_cnt++;
      chk_cnt++; if (um_data !== 32'hA0000000) $display("FAIL cont_first_data: got %h want a0000000", um_data); else pass_cnt++;
      chk_cnt++; if (req_ready !== 4'b0001) $display("FAIL cont_first_ready: got %b want 0001", req_ready); else pass_cnt++;
      @(negedge clk);
      drive(0, 1'b1, 1'b1, 1'b1, 32'hA0000002);
      #1;
      chk_cnt++; if (grant !== 4'b0000) $display("FAIL cont_bubble: got %b want 0000", grant); else pass_cnt++;
      chk_cnt++; if (um_valid !== 1'b0) $display("FAIL cont_bubble_valid: got %b want 0", um_valid); else pass_cnt++;
      @(negedge clk); #1;
      chk_cnt++; if (grant !== 4'b0100) $display("FAIL cont_second: got %b want 0100", grant); else pass_cnt++;
      chk_cnt++; if (um_data !== 32'hC0000001) $display("FAIL cont_second_data: got %h want c0000001", um_data); else pass_cnt++;
      chk_cnt++; if (req_ready !== 4'b0100) $display("FAIL cont_second_ready: got %b want 0100", req_ready); else pass_cnt++;
      @(negedge clk);
      drive(2, 1'b1, 1'b0, 1'b1, 32'hC0000003);
      #1;
      chk_cnt++; if (um_data !== 32'hC0000003) $display("FAIL cont_second_eop: got %h want c0000003", um_data); else pass_cnt++;
      chk_cnt++; if (req_ready !== 4'b0100) $display("FAIL cont_src0_held: got %b want 0100", req_ready); else pass_cnt++;
      @(negedge clk);
      drive(2, 1'b0, 1'b0, 1'b0, 32'h0);
      #1;
      chk_cnt++; if (grant !== 4'b0000) $display("FAIL cont_bubble2: got %b want 0000", grant); else pass_cnt++;
      @(negedge clk); #1;
      chk_cnt++; if (grant !== 4'b0001) $display("FAIL cont_third: got %b want 0001", grant); else pass_cnt++;
      chk_cnt++; if (um_data !== 32'hA0000002) $display("FAIL cont_third_data: got %h want a0000002", um_data); else pass_cnt++;
      @(negedge clk);
      drive(0, 1'b0, 1'b0, 1'b0, 32'h0);
      #1;
      chk_cnt++; if (busy !== 1'b0) $display("FAIL cont_done: got %b want 0", busy); else pass_cnt++;
   endtask

   task automatic test_no_interleave();
      @(negedge clk);
      drive(3, 1'b1, 1'b1, 1'b0, 32'h33333333);
      @(negedge clk); #1;
      chk_cnt++; if (grant !== 4'b1000) $display("FAIL nil_grant3: got %b want 1000", grant); else pass_cnt++;
      @(negedge clk);
      drive(3, 1'b1, 1'b0, 1'b0, 32'h55555555);
      drive(0, 1'b1, 1'b1, 1'b1, 32'h0000000F);
      #1;
      chk_cnt++; if (um_data !== 32'h55555555) $display("FAIL nil_mid_data: got %h want 55555555", um_data); else pass_cnt++;
      chk_cnt++; if (req_ready !== 4'b1000) $display("FAIL nil_mid_ready: got %b want 1000", req_ready); else pass_cnt++;
      @(negedge clk);
      drive(3, 1'b1, 1'b0, 1'b1, 32'hAAAAAAAA);
      #1;
      chk_cnt++; if (um_data !== 32'hAAAAAAAA) $display("FAIL nil_eop_data: got %h want aaaaaaaa", um_data); else pass_cnt++;
      chk_cnt++; if (req_ready !== 4'b1000) $display("FAIL nil_eop_ready: got %b want 1000", req_ready); else pass_cnt++;
      @(negedge clk);
      drive(3, 1'b0, 1'b0, 1'b0, 32'h0);
      #1;
      chk_cnt++; if (req_ready !== 4'b0000) $display("FAIL nil_bubble_ready: got %b want 0000", req_ready); else pass_cnt++;
      @(negedge clk); #1;
      chk_cnt++; if (grant !== 4'b0001) $display("FAIL nil_grant0: got %b want 0001", grant); else pass_cnt++;
      chk_cnt++; if (um_data !== 32'h0000000F) $display("FAIL nil_src0_data: got %h want 0000000f", um_data); else pass_cnt++;
      @(negedge clk);
      drive(0, 1'b0, 1'b0, 1'b0, 32'h0);
      #1;
      chk_cnt++; if (grant !== 4'b0000) $display("FAIL nil_release: got %b want 0000", grant); else pass_cnt++;
   endtask

   task automatic test_backpressure();
      int a0;
      a0 = acc_cnt;
      @(negedge clk);
      drive(1, 1'b1, 1'b1, 1'b0, 32'h10000000);
      @(negedge clk); #1;
      chk_cnt++; if (grant !== 4'b0010) $display("FAIL bp_grant: got %b want 0010", grant); else pass_cnt++;
      chk_cnt++; if (um_data !== 32'h10000000) $display("FAIL bp_beat0: got %h want 10000000", um_data); else pass_cnt++;
      @(negedge clk);
      drive(1, 1'b1, 1'b1, 1'b0, 32'h10000001);
      um_ready = 1'b0;
      #1;
      chk_cnt++; if (req_ready !== 4'b0000) $display("FAIL bp_ready_low: got %b want 0000", req_ready); else pass_cnt++;
      chk_cnt++; if (um_sop !== 1'b1) $display("FAIL bp_mid_sop: got %b want 1", um_sop); else pass_cnt++;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); #1;
         chk_cnt++; if (req_ready !== 4'b0000) $display("FAIL bp_hold_ready%0d: got %b want 0000", k, req_ready); else pass_cnt++;
         chk_cnt++; if (um_data !== 32'h10000001) $display("FAIL bp_hold_data%0d: got %h want 10000001", k, um_data); else pass_cnt++;
      end
      chk_cnt++; if (grant !== 4'b0010) $display("FAIL bp_hold_grant: got %b want 0010", grant); else pass_cnt++;
      chk_cnt++; if (acc_cnt - a0 !== 1) $display("FAIL bp_stalled_beats: got %0d want 1", acc_cnt - a0); else pass_cnt++;
      @(negedge clk);
      um_ready = 1'b1;
      #1;
      chk_cnt++; if (req_ready !== 4'b0010) $display("FAIL bp_ready_back: got %b want 0010", req_ready); else pass_cnt++;
      @(negedge clk);
      drive(1, 1'b1, 1'b0, 1'b1, 32'h10000002);
      #1;
      chk_cnt++; if (um_data !== 32'h10000002) $display("FAIL bp_beat2: got %h want 10000002", um_data); else pass_cnt++;
      chk_cnt++; if (acc_cnt - a0 !== 2) $display("FAIL bp_beats_mid: got %0d want 2", acc_cnt - a0); else pass_cnt++;
      @(negedge clk);
      drive(1, 1'b0, 1'b0, 1'b0, 32'h0);
      #1;
      chk_cnt++; if (grant !== 4'b0000) $display("FAIL bp_release: got %b want 0000", grant); else pass_cnt++;
      chk_cnt++; if (acc_cnt - a0 !== 3) $display("FAIL bp_beats_total: got %0d want 3", acc_cnt - a0); else pass_cnt++;
   endtask

   task automatic test_reset_mid_packet();
      @(negedge clk);
      drive(2, 1'b1, 1'b1, 1'b0, 32'h22220000);
      @(negedge clk); #1;
      chk_cnt++; if (grant !== 4'b0100) $display("FAIL rmp_grant: got %b want 0100", grant); else pass_cnt++;
      @(negedge clk);
      drive(2, 1'b1, 1'b0, 1'b0, 32'h22220001);
      #1;
      chk_cnt++; if (um_data !== 32'h22220001) $display("FAIL rmp_mid_data: got %h want 22220001", um_data); else pass_cnt++;
      #1;
      rst = 1'b0;
      #1;
      chk_cnt++; if (grant !== 4'b0000) $display("FAIL rmp_grant_clr: got %b want 0000", grant); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b0) $display("FAIL rmp_busy_clr: got %b want 0", busy); else pass_cnt++;
      chk_cnt++; if (req_ready !== 4'b0000) $display("FAIL rmp_ready_clr: got %b want 0000", req_ready); else pass_cnt++;
      chk_cnt++; if (um_valid !== 1'b0) $display("FAIL rmp_valid_clr: got %b want 0", um_valid); else pass_cnt++;
      @(negedge clk);
      rst = 1'b1;
      clear_all();
      @(negedge clk);
      drive(0, 1'b1, 1'b1, 1'b1, 32'h0A0A0A0A);
      drive(3, 1'b1, 1'b1, 1'b1, 32'h3A3A3A3A);
      @(negedge clk); #1;
      chk_cnt++; if (grant !== 4'b0001) $display("FAIL rmp_restart: got %b want 0001", grant); else pass_cnt++;
      @(negedge clk);
      drive(0, 1'b0, 1'b0, 1'b0, 32'h0);
      @(negedge clk); #1;
      chk_cnt++; if (grant !== 4'b1000) $display("FAIL rmp_next: got %b want 1000", grant); else pass_cnt++;
      chk_cnt++; if (um_data !== 32'h3A3A3A3A) $display("FAIL rmp_next_data: got %h want 3a3a3a3a", um_data); else pass_cnt++;
      @(negedge clk);
      clear_all();
      #1;
      chk_cnt++; if (grant !== 4'b0000) $display("FAIL rmp_release: got %b want 0000", grant); else pass_cnt++;
   endtask

`ifdef UNPACK_ARB_TIMEOUT_EN
   task automatic test_timeout();
      @(negedge clk);
      drive(2, 1'b1, 1'b1, 1'b0, 32'h00000002);
      @(negedge clk); #1;
      chk_cnt++; if (grant !== 4'b0100) $display("FAIL to_grant: got %b want 0100", grant); else pass_cnt++;
      @(negedge clk);
      drive(2, 1'b0, 1'b0, 1'b0, 32'h0);
      #1;
      chk_cnt++; if (timeout !== 1'b0) $display("FAIL to_early0: got %b want 0", timeout); else pass_cnt++;
      for (int k = 1; k < TIMEOUT; k++) begin
         @(negedge clk); #1;
         chk_cnt++; if (timeout !== 1'b0) $display("FAIL to_early%0d: got %b want 0", k, timeout); else pass_cnt++;
      end
      @(negedge clk);
      um_ready = 1'b0;
      #1;
      chk_cnt++; if (timeout !== 1'b1) $display("FAIL to_pulse: got %b want 1", timeout); else pass_cnt++;
      chk_cnt++; if ({um_valid, um_eop} !== 2'b11) $display("FAIL to_inject_ctl: got %b want 11", {um_valid, um_eop}); else pass_cnt++;
      chk_cnt++; if (um_data !== 32'h0) $display("FAIL to_inject_data: got %h want 0", um_data); else pass_cnt++;
      chk_cnt++; if (req_ready !== 4'b0000) $display("FAIL to_inject_ready: got %b want 0000", req_ready); else pass_cnt++;
      @(negedge clk); #1;
      chk_cnt++; if (timeout !== 1'b0) $display("FAIL to_pulse_end: got %b want 0", timeout); else pass_cnt++;
      chk_cnt++; if ({um_valid, um_eop} !== 2'b11) $display("FAIL to_inject_hold: got %b want 11", {um_valid, um_eop}); else pass_cnt++;
      um_ready = 1'b1;
      @(negedge clk); #1;
      chk_cnt++; if (grant !== 4'b0000) $display("FAIL to_release: got %b want 0000", grant); else pass_cnt++;
      drive(0, 1'b1, 1'b1, 1'b1, 32'h0000000A);
      drive(3, 1'b1, 1'b1, 1'b1, 32'h0000003A);
      @(negedge clk); #1;
      chk_cnt++; if (grant !== 4'b1000) $display("FAIL to_next_rr: got %b want 1000", grant); else pass_cnt++;
      @(negedge clk);
      clear_all();
   endtask
`endif

   initial begin
      rst      = 1'b0;
      um_ready = 1'b0;
      clear_all();
      test_reset();
      test_single_source();
      test_contention();
      test_no_interleave();
      test_backpressure();
      test_reset_mid_packet();
`ifdef UNPACK_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/unpack_pkt_arbiter.md
# unpack_pkt_arbiter

Packet-level round-robin arbiter that shares a single `data_unpack` instance between `N_REQ` upstream packet sources. It locks the grant from the start-of-packet beat to the end-of-packet beat, so packets are never interleaved at the unpacker input. It passes the unpacker's `ready_out` back only to the granted source. The block sits between the source muxing layer and the `data_unpack` `valid_in`/`data_in`/`sop_in`/`eop_in`/`ready_out` port.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `DATA_W`, 32: beat width; matches the unpacker `data_in`.
- `TIMEOUT`, 64: stall limit in cycles; used only with `UNPACK_ARB_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in N_REQ: per-source beat valid.
- `req_data` in N_REQ*DATA_W: per-source beat. Source i occupies bits [i*DATA_W +: DATA_W].
- `req_sop` in N_REQ: per-source start-of-packet flag.
- `req_eop` in N_REQ: per-source end-of-packet flag.
- `req_ready` out N_REQ: per-source ready; at most one bit set.
- `um_valid` out 1: drives the unpacker `valid_in`.
- `um_data` out DATA_W: drives the unpacker `data_in`.
- `um_sop` out 1: drives the unpacker `sop_in`.
- `um_eop` out 1: drives the unpacker `eop_in`.
- `um_ready` in 1: driven by the unpacker `ready_out`.
- `grant` out N_REQ: one-hot current owner; all zero when idle.
- `busy` out 1: high while a packet is locked.
- `timeout` out 1: one-cycle abort pulse. Present only with `UNPACK_ARB_TIMEOUT_EN`.

## Operation
- **FSM states:** IDLE and LOCK.
- **Reset values:**
  - state = IDLE, rr pointer = 0.
  - `grant` = 0, `busy` = 0, `req_ready` = 0.
  - `um_valid`, `um_sop`, `um_eop` = 0; `um_data` = 0.
  - `timeout` = 0.
- **Eligibility:** source i is eligible when `req_valid[i] && req_sop[i]`. A valid beat without sop while idle is not eligible; that source sees `req_ready` low and stalls.
- **IDLE behaviour:**
  - The winner is the first eligible source scanning from the rr pointer upward, with wrap-around modulo N_REQ.
  - On a win, register `grant` = onehot(winner) and `busy` = 1, then go to LOCK.
  - With no eligible source, stay in IDLE.
- **LOCK behaviour:**
  - Combinational pass-through from granted source g: `um_valid` = `req_valid[g]`, `um_data`/`um_sop`/`um_eop` = source g fields, `req_ready[g]` = `um_ready`.
  - All other `req_ready` bits are 0.
- **Beat acceptance:** a beat is accepted when `um_valid && um_ready`.
  - On an accepted beat with `um_eop` = 1: go to IDLE, set rr pointer = g+1 mod N_REQ, clear `grant` and `busy`.
  - An sop seen mid-packet is forwarded unchanged and has no effect on arbitration.
- **Reset mid-packet:** all state returns to reset values immediately (asynchronous). The unpacker is reset by the same `rst`.
- **Outputs when idle:** `um_*` are forced to 0.

## Timing
- **Arbitration latency:** 1 cycle. An eligible sop presented at edge n is granted after edge n; the first beat can be accepted in that same LOCK cycle (n+1).
- **Inter-packet gap:** exactly one IDLE bubble cycle between packets.
- **Per-beat throughput:** limited only by `um_ready`. The arbiter adds no per-beat latency (pass-through).
- **Simultaneous requests:** the rr pointer order decides; a source that just finished has lowest priority next round.
- **Sop-and-eop beat:** a single-beat packet (sop and eop both set) locks and releases in one LOCK cycle.

## Configuration
- **Macro:** `UNPACK_ARB_TIMEOUT_EN`.
- **Defined:**
  - A stall counter ($clog2(TIMEOUT+1) bits) counts consecutive LOCK cycles with `req_valid[g]` = 0. It resets on any cycle where `req_valid[g]` is high and on entry to LOCK.
  - When the counter reaches TIMEOUT:
    - pulse `timeout` for 1 cycle;
    - drive one beat to the unpacker with `um_valid` = 1, `um_data` = 0, `um_eop` = 1, holding until `um_ready`;
    - on acceptance, release to IDLE with rr pointer = g+1.
  - `req_ready[g]` = 0 during the injected beat.
- **Not defined:** no counter and no `timeout` port; a stalled owner holds the lock indefinitely.

## Test plan
- **Single source:** N_REQ=4, source 1 sends 2 beats 0x12345678 (sop) and 0x9abcdef0 (eop).
  - `grant` = 0010 one cycle after sop.
  - `um_data` matches both beats in order.
  - `grant` = 0000 after the eop is accepted.
- **Contention:** sources 0 and 2 both assert sop at reset exit.
  - Source 0 is served first, then source 2 after one bubble.
  - Repeating the contention puts source 2 ahead of source 0; `req_ready[0]` stays 0 while source 2 is locked.
- **No interleave:** while source 3 is mid-packet (beat 0x55555555), source 0 raises sop.
  - `req_ready[0]` stays 0 until source 3's eop 0xAAAAAAAA is accepted.
  - Source 0 is then granted.
- **Backpressure:** `um_ready` is held low for 5 cycles mid-packet.
  - `req_ready[g]` follows it; `um_data` stays stable; no beat is lost or duplicated.
- **Reset mid-packet:** assert `rst` = 0 during a lock.
  - `grant`, `busy`, `req_ready`, and `um_valid` read 0 in the same cycle.
  - After release, arbitration restarts with the rr pointer at 0.
- **Timeout (macro defined, TIMEOUT=8):** source 2 sends sop, then drops valid for 8 cycles.
  - `timeout` pulses.
  - A zero-data eop beat is accepted by the unpacker.
  - `grant` clears; the next round starts at source 3.
